tl_tile_a_d_arbiter: RTL

Shares one downstream TileLink A/D channel pair between up to four packed Rocket tiles. A-channel requests are arbitrated round-robin and tagged with the tile index in the upper source bits. D-channel responses are routed back by that tag, and a per-tile outstanding-request limit is enforced. It sits between the tiles' packed buffer ports and the memory-side interconnect. B/C/E channels are handled by a separate block.

---
 rtl/tl_bus_pkg.sv | 70 +++++++
 rtl/tl_rr_arbiter.sv | 47 ++++
 rtl/tl_tile_a_d_arbiter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/tl_bus_pkg.sv
// ----------------------------------------------------------------------------
// tl_bus_pkg
//   Shared TileLink A/D beat layouts for the tile-side packed buffer ports
//   (2-bit source) and the memory-side interconnect (4-bit source). The bus
//   source is {tile_idx, tile_src}.
//   All beats are single-beat with a 64-byte data field.
// ----------------------------------------------------------------------------
package tl_bus_pkg;

    localparam int BUS_SRC_W  = 4;
    localparam int TILE_SRC_W = 2;
    localparam int TILE_IDX_W = BUS_SRC_W - TILE_SRC_W;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 512;
    localparam int MASK_W     = DATA_W / 8;
    localparam int SIZE_W     = 4;
    localparam int SINK_W     = 4;
    localparam int CNT_W      = 4;

    localparam logic [2:0] TL_D_RELEASEACK = 3'd6;

    // Tile-side A beat
    typedef struct packed {
        logic [2:0]            opcode;
        logic [2:0]            param;
        logic [SIZE_W-1:0]     size;
        logic [TILE_SRC_W-1:0] source;
        logic [ADDR_W-1:0]     address;
        logic [MASK_W-1:0]     mask;
        logic [DATA_W-1:0]     data;
        logic                  corrupt;
    } TLreqApacked_t;

    // Bus-side A beat
    typedef struct packed {
        logic [2:0]           opcode;
        logic [2:0]           param;
        logic [SIZE_W-1:0]    size;
        logic [BUS_SRC_W-1:0] source;
        logic [ADDR_W-1:0]    address;
        logic [MASK_W-1:0]    mask;
        logic [DATA_W-1:0]    data;
        logic                 corrupt;
    } TLbusApacked_t;

    // Tile-side D beat
    typedef struct packed {
        logic [2:0]            opcode;
        logic [1:0]            param;
        logic [SIZE_W-1:0]     size;
        logic [TILE_SRC_W-1:0] source;
        logic [SINK_W-1:0]     sink;
        logic                  denied;
        logic [DATA_W-1:0]     data;
        logic                  corrupt;
    } TLreqDpacked_t;

    // Bus-side D beat
    typedef struct packed {
        logic [2:0]           opcode;
        logic [1:0]           param;
        logic [SIZE_W-1:0]    size;
        logic [BUS_SRC_W-1:0] source;
        logic [SINK_W-1:0]    sink;
        logic                 denied;
        logic [DATA_W-1:0]    data;
        logic                 corrupt;
    } TLbusDpacked_t;

endpackage

// File: rtl/tl_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tl_rr_arbiter
//   Combinational round-robin selector. It scans the request vector starting
//   at (ptr+1) mod N and grants the first requester found. The pointer
//   register itself lives in the parent, which loads next_ptr every cycle.
//   Ports:
//     req       in  N   request vector
//     ptr       in  2   current round-robin pointer (last granted index)
//     advance   in  1   grant is being consumed this cycle
//     gnt       out N   one-hot grant
//     gnt_idx   out 2   index of the granted requester
//     gnt_valid out 1   some requester is granted
//     next_ptr  out 2   gnt_idx when advancing with a grant, else ptr
// ----------------------------------------------------------------------------
module tl_rr_arbiter
    import tl_bus_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]          req,
    input  logic [TILE_IDX_W-1:0] ptr,
    input  logic                  advance,
    output logic [N-1:0]          gnt,
    output logic [TILE_IDX_W-1:0] gnt_idx,
    output logic                  gnt_valid,
    output logic [TILE_IDX_W-1:0] next_ptr
);

    always_comb begin
        int j;
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        j         = 0;
        for (int k = 1; k <= N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!gnt_valid && req[j]) begin
                gnt_valid = 1'b1;
                gnt[j]    = 1'b1;
                gnt_idx   = TILE_IDX_W'(j);
            end
        end
    end

    assign next_ptr = (advance && gnt_valid) ? gnt_idx : ptr;

endmodule

// File: rtl/tl_tile_a_d_arbiter.sv
// ----------------------------------------------------------------------------
// tl_tile_a_d_arbiter
//   Shares one downstream TileLink A/D channel pair between up to four tiles.
//   A requests are arbitrated round-robin into a one-entry output slice and
//   tagged with the tile index in source[3:2]. D responses are routed back
//   combinationally by source[3:2]. Each tile may have at most MAX_OUT
//   A requests outstanding (counted until a non-ReleaseAck D returns).
//
//   Handshake rule on every channel: a beat transfers in a cycle where both
//   valid and ready are high; a valid beat is held stable until it transfers.
//
//   Ports:
//     clock_i, reset_i         clock, synchronous active-high reset
//     tile_a_valid_i/beat_i    per-tile A requests (2-bit source)
//     tile_a_ready_o           per-tile A ready, only for the granted tile
//     tile_d_valid_o           per-tile D valid
//     tile_d_beat_o            D beat shared by all tiles (2-bit source)
//     tile_d_ready_i           per-tile D ready
//     bus_a_valid_o/beat_o     downstream A (4-bit source), bus_a_ready_i
//     bus_d_valid_i/beat_i     downstream D (4-bit source), bus_d_ready_o
//     route_err_o              sticky: unroutable D or counter underflow
// ----------------------------------------------------------------------------
module tl_tile_a_d_arbiter
    import tl_bus_pkg::*;
#(
    parameter int N_TILES = 2,
    parameter int MAX_OUT = 4
) (
    input  logic                        clock_i,
    input  logic                        reset_i,
    input  logic          [N_TILES-1:0] tile_a_valid_i,
    input  TLreqApacked_t [N_TILES-1:0] tile_a_beat_i,
    output logic          [N_TILES-1:0] tile_a_ready_o,
    output logic          [N_TILES-1:0] tile_d_valid_o,
    output TLreqDpacked_t               tile_d_beat_o,
    input  logic          [N_TILES-1:0] tile_d_ready_i,
    output logic                        bus_a_valid_o,
    output TLbusApacked_t               bus_a_beat_o,
    input  logic                        bus_a_ready_i,
    input  logic                        bus_d_valid_i,
    input  TLbusDpacked_t               bus_d_beat_i,
    output logic                        bus_d_ready_o,
    output logic                        route_err_o
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                  slice_valid;
    TLbusApacked_t         slice_beat;
    logic [TILE_IDX_W-1:0] rr_ptr;
    logic [CNT_W-1:0]      cnt [N_TILES];
    logic                  route_err;

    // ------------------------------------------------------------------
    // A path
    // ------------------------------------------------------------------
    logic [N_TILES-1:0]    eligible;
    logic [N_TILES-1:0]    gnt;
    logic [TILE_IDX_W-1:0] gnt_idx;
    logic                  gnt_valid;
    logic [TILE_IDX_W-1:0] next_ptr;
    logic                  accept;
    logic                  a_fire;
    TLreqApacked_t         sel_beat;

    // Eligibility uses the registered count, so a request arriving in the
    // cycle its tile reaches MAX_OUT waits.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < N_TILES; i++) begin
            eligible[i] = tile_a_valid_i[i] && (cnt[i] < CNT_W'(MAX_OUT));
        end
    end

    tl_rr_arbiter #(.N(N_TILES)) u_rr (
        .req       (eligible),
        .ptr       (rr_ptr),
        .advance   (a_fire),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .next_ptr  (next_ptr)
    );

    // The slice can take a new beat when it is empty or draining this cycle.
    assign accept         = !reset_i && (!slice_valid || bus_a_ready_i);
    assign a_fire         = accept && gnt_valid;
    assign tile_a_ready_o = accept ? gnt : '0;

    always_comb begin
        sel_beat = '0;
        for (int i = 0; i < N_TILES; i++) begin
            if (gnt[i]) sel_beat = tile_a_beat_i[i];
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            slice_valid <= 1'b0;
            slice_beat  <= '0;
            rr_ptr      <= TILE_IDX_W'(N_TILES - 1);
        end else begin
            rr_ptr <= next_ptr;
            if (accept) begin
                slice_valid <= gnt_valid;
                if (gnt_valid) begin
                    slice_beat.opcode  <= sel_beat.opcode;
                    slice_beat.param   <= sel_beat.param;
                    slice_beat.size    <= sel_beat.size;
                    slice_beat.source  <= {gnt_idx, sel_beat.source};
                    slice_beat.address <= sel_beat.address;
                    slice_beat.mask    <= sel_beat.mask;
                    slice_beat.data    <= sel_beat.data;
                    slice_beat.corrupt <= sel_beat.corrupt;
                end
            end
        end
    end

    assign bus_a_valid_o = slice_valid;
    assign bus_a_beat_o  = slice_beat;

    // ------------------------------------------------------------------
    // D path (purely combinational)
    // ------------------------------------------------------------------
    logic [TILE_IDX_W-1:0] d_idx;
    logic                  d_routable;
    logic                  d_sel_ready;
    logic                  d_fire;
    logic [N_TILES-1:0]    inc;
    logic [N_TILES-1:0]    dec;
    logic [N_TILES-1:0]    underflow;

    assign d_idx      = bus_d_beat_i.source[BUS_SRC_W-1:TILE_SRC_W];
    assign d_routable = int'(d_idx) < N_TILES;

    always_comb begin
        tile_d_valid_o = '0;
        d_sel_ready    = 1'b0;
        for (int i = 0; i < N_TILES; i++) begin
            if (int'(d_idx) == i) begin
                tile_d_valid_o[i] = bus_d_valid_i;
                d_sel_ready       = tile_d_ready_i[i];
            end
        end
    end

    // Unroutable beats are sunk so the bus never stalls on them.
    assign bus_d_ready_o = d_routable ? d_sel_ready : 1'b1;
    assign d_fire        = bus_d_valid_i && bus_d_ready_o;

    assign tile_d_beat_o.opcode  = bus_d_beat_i.opcode;
    assign tile_d_beat_o.param   = bus_d_beat_i.param;
    assign tile_d_beat_o.size    = bus_d_beat_i.size;
    assign tile_d_beat_o.source  = bus_d_beat_i.source[TILE_SRC_W-1:0];
    assign tile_d_beat_o.sink    = bus_d_beat_i.sink;
    assign tile_d_beat_o.denied  = bus_d_beat_i.denied;
    assign tile_d_beat_o.data    = bus_d_beat_i.data;
    assign tile_d_beat_o.corrupt = bus_d_beat_i.corrupt;

    // ------------------------------------------------------------------
    // Outstanding counters and error flag
    // ------------------------------------------------------------------
    always_comb begin
        inc       = '0;
        dec       = '0;
        underflow = '0;
        for (int i = 0; i < N_TILES; i++) begin
            inc[i]       = a_fire && gnt[i];
            dec[i]       = d_fire && d_routable && (int'(d_idx) == i) &&
                           (bus_d_beat_i.opcode != TL_D_RELEASEACK);
            underflow[i] = dec[i] && !inc[i] && (cnt[i] == '0);
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int i = 0; i < N_TILES; i++) cnt[i] <= '0;
            route_err <= 1'b0;
        end else begin
            for (int i = 0; i < N_TILES; i++) begin
                case ({inc[i], dec[i]})
                    2'b10:   cnt[i] <= cnt[i] + CNT_W'(1);
                    2'b01:   if (cnt[i] != '0) cnt[i] <= cnt[i] - CNT_W'(1);
                    default: cnt[i] <= cnt[i];
                endcase
            end
            if ((bus_d_valid_i && !d_routable) || (|underflow)) route_err <= 1'b1;
        end
    end

    assign route_err_o = route_err;

endmodule
